fp_cmp_seq_d: RTL and testbench

//  Issue/writeback sequencer for the D-extension compare path (FEQ.D, FLT.D, FLE.D).
//  - Accepts decoded compare instructions from the FP issue stage over valid/ready.
//  - Buffers them, then drives the external combinational double comparator with stable a/b/op.
//  - Registers the 1-bit compare result as an XLEN integer writeback with rd tag and fflags.
//  - NV (invalid) flag is generated here per IEEE 754 / RISC-V signalling rules.

---
 rtl/fp_d_pkg.sv | 29 ++
 rtl/fp_cmp_seq_d_if.sv | 43 ++++
 rtl/fp_d_classify.sv | 18 +
 rtl/fp_cmp_seq_d.sv | 118 +++++++++++
 tb/tb_fp_cmp_seq_d.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fp_d_pkg.sv
// Shared encodings for the D-extension compare path: funct3 codes, comparator
// op encodings, IEEE 754 double field constants and the funct3 decoder.
package fp_d_pkg;

  localparam logic [2:0] FUNCT3_FLE = 3'b000;
  localparam logic [2:0] FUNCT3_FLT = 3'b001;
  localparam logic [2:0] FUNCT3_FEQ = 3'b010;

  typedef enum logic [1:0] {
    CMP_OP_LE   = 2'b00,
    CMP_OP_NONE = 2'b01,
    CMP_OP_EQ   = 2'b10,
    CMP_OP_LT   = 2'b11
  } cmp_op_e;

  localparam logic [10:0] EXP_ALL_ONES = 11'h7FF;
  localparam int unsigned QNAN_BIT     = 51;
  localparam int unsigned FFLAG_NV     = 4;

  function automatic cmp_op_e decode_op(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_FLE: return CMP_OP_LE;
      FUNCT3_FLT: return CMP_OP_LT;
      FUNCT3_FEQ: return CMP_OP_EQ;
      default:    return CMP_OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fp_cmp_seq_d_if.sv
// Issue, comparator and writeback bundle of the compare sequencer.
// master = sequencer side, slave = surrounding pipeline / comparator.
interface fp_cmp_seq_d_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_rs1;
  logic [63:0]     in_rs2;
  logic [2:0]      in_funct3;
  logic [RD_W-1:0] in_rd;

  logic [63:0]     cmp_a;
  logic [63:0]     cmp_b;
  logic [1:0]      cmp_op;
  logic            cmp_result;

  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_fflags;
  logic            wb_illegal;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_funct3, in_rd,
    output in_ready,
    output cmp_a, cmp_b, cmp_op,
    input  cmp_result,
    output wb_valid, wb_rd, wb_data, wb_fflags, wb_illegal,
    input  wb_ready
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_funct3, in_rd,
    input  in_ready,
    input  cmp_a, cmp_b, cmp_op,
    output cmp_result,
    input  wb_valid, wb_rd, wb_data, wb_fflags, wb_illegal,
    output wb_ready
  );
endinterface

// File: rtl/fp_d_classify.sv
// Combinational NaN / signalling-NaN detection for one IEEE 754 double.
module fp_d_classify
  import fp_d_pkg::*;
(
  input  logic [63:0] val,
  output logic        is_nan,
  output logic        is_snan
);

  logic [10:0] exp_f;
  logic [51:0] mant_f;

  assign exp_f   = val[62:52];
  assign mant_f  = val[51:0];
  assign is_nan  = (exp_f == EXP_ALL_ONES) && (mant_f != '0);
  assign is_snan = is_nan && !mant_f[QNAN_BIT];

endmodule

// File: rtl/fp_cmp_seq_d.sv
// Issue/writeback sequencer for FEQ.D/FLT.D/FLE.D: buffers decoded compares,
// presents the head entry to an external comparator, registers the writeback.
module fp_cmp_seq_d
  import fp_d_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  fp_cmp_seq_d_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [63:0]     rs1_q [DEPTH];
  logic [63:0]     rs2_q [DEPTH];
  cmp_op_e         op_q  [DEPTH];
  logic [RD_W-1:0] rd_q  [DEPTH];
  logic            nv_q  [DEPTH];
  logic            ill_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;

  logic            wb_valid_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic [4:0]      wb_fflags_q;
  logic            wb_illegal_q;

  logic    a_nan, a_snan, b_nan, b_snan;
  cmp_op_e op_in;
  logic    ill_in;
  logic    nv_in;

  fp_d_classify u_cls_a (.val(bus.in_rs1), .is_nan(a_nan), .is_snan(a_snan));
  fp_d_classify u_cls_b (.val(bus.in_rs2), .is_nan(b_nan), .is_snan(b_snan));

  assign op_in  = decode_op(bus.in_funct3);
  assign ill_in = (op_in == CMP_OP_NONE);

  // FEQ is quiet (only sNaN signals); FLT/FLE signal on any NaN.
  always_comb begin
    nv_in = 1'b0;
    case (op_in)
      CMP_OP_EQ:           nv_in = a_snan | b_snan;
      CMP_OP_LT, CMP_OP_LE: nv_in = a_nan | b_nan;
      default:             nv_in = 1'b0;
    endcase
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && (!wb_valid_q || bus.wb_ready);

  assign bus.in_ready = !full;
  assign bus.cmp_a    = empty ? '0 : rs1_q[rd_ptr];
  assign bus.cmp_b    = empty ? '0 : rs2_q[rd_ptr];
  assign bus.cmp_op   = empty ? CMP_OP_NONE : op_q[rd_ptr];

  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_fflags  = wb_fflags_q;
  assign bus.wb_illegal = wb_illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      wb_fflags_q  <= '0;
      wb_illegal_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wb_valid_q <= 1'b0;
    end else begin
      if (push) begin
        rs1_q[wr_ptr] <= bus.in_rs1;
        rs2_q[wr_ptr] <= bus.in_rs2;
        op_q[wr_ptr]  <= op_in;
        rd_q[wr_ptr]  <= bus.in_rd;
        nv_q[wr_ptr]  <= nv_in;
        ill_q[wr_ptr] <= ill_in;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        wb_valid_q   <= 1'b1;
        wb_rd_q      <= rd_q[rd_ptr];
        wb_data_q    <= XLEN'(bus.cmp_result && !ill_q[rd_ptr]);
        wb_fflags_q  <= {nv_q[rd_ptr], 4'b0000};
        wb_illegal_q <= ill_q[rd_ptr];
      end else if (bus.wb_ready) begin
        wb_valid_q <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_cmp_seq_d.sv
// Directed bench for fp_cmp_seq_d with a behavioural double comparator stand-in.
module tb_fp_cmp_seq_d;
  import fp_d_pkg::*;

  localparam logic [63:0] ONE     = 64'h3FF0000000000000;
  localparam logic [63:0] TWO     = 64'h4000000000000000;
  localparam logic [63:0] NEG_ONE = 64'hBFF0000000000000;
  localparam logic [63:0] PZERO   = 64'h0000000000000000;
  localparam logic [63:0] NZERO   = 64'h8000000000000000;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;
  localparam logic [63:0] SNAN    = 64'h7FF0000000000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  fp_cmp_seq_d_if #(.XLEN(64), .RD_W(5)) bus ();

  fp_cmp_seq_d #(.XLEN(64), .DEPTH(2), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.master)
  );

  function automatic logic is_nan_d(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic [63:0] order_key(input logic [63:0] x);
    return x[63] ? ~x : (x | 64'h8000000000000000);
  endfunction

  function automatic logic ref_cmp(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op);
    logic nan, bothz, eq, lt;
    nan   = is_nan_d(a) || is_nan_d(b);
    bothz = (a[62:0] == 63'd0) && (b[62:0] == 63'd0);
    eq    = !nan && ((a == b) || bothz);
    lt    = !nan && !bothz && (order_key(a) < order_key(b));
    case (op)
      2'b10:   return eq;
      2'b11:   return lt;
      2'b00:   return lt || eq;
      default: return 1'b0;
    endcase
  endfunction

  always_comb bus.cmp_result = ref_cmp(bus.cmp_a, bus.cmp_b, bus.cmp_op);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f3;
    bus.in_rs1    = a;
    bus.in_rs2    = b;
    bus.in_rd     = rd;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_wb(input string tag, input logic d, input logic [4:0] fl,
                           input logic [4:0] rd, input logic ill);
    check({tag, ".valid"},   64'(bus.wb_valid),   64'd1);
    check({tag, ".data"},    bus.wb_data,         64'(d));
    check({tag, ".fflags"},  64'(bus.wb_fflags),  64'(fl));
    check({tag, ".rd"},      64'(bus.wb_rd),      64'(rd));
    check({tag, ".illegal"}, 64'(bus.wb_illegal), 64'(ill));
  endtask

  task automatic single_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [1:0] op,
                           input logic d, input logic [4:0] fl, input logic ill);
    drive(f3, a, b, rd);
    step();
    idle();
    check({tag, ".lat"}, 64'(bus.wb_valid), 64'd0);
    check({tag, ".op"},  64'(bus.cmp_op),   64'(op));
    step();
    expect_wb(tag, d, fl, rd, ill);
    step();
    check({tag, ".drop"}, 64'(bus.wb_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_rd     = '0;
    bus.wb_ready  = 1'b1;

    rst_n = 1'b0;
    step();
    step();
    check("rst.wb_valid",   64'(bus.wb_valid),   64'd0);
    check("rst.in_ready",   64'(bus.in_ready),   64'd1);
    check("rst.cmp_op",     64'(bus.cmp_op),     64'd1);
    check("rst.cmp_a",      bus.cmp_a,           64'd0);
    check("rst.cmp_b",      bus.cmp_b,           64'd0);
    check("rst.wb_data",    bus.wb_data,         64'd0);
    check("rst.wb_fflags",  64'(bus.wb_fflags),  64'd0);
    check("rst.wb_rd",      64'(bus.wb_rd),      64'd0);
    check("rst.wb_illegal", 64'(bus.wb_illegal), 64'd0);
    rst_n = 1'b1;
    step();

    single_op("flt_1_2",    3'b001, ONE,     TWO,   5'd3,  2'b11, 1'b1, 5'h00, 1'b0);
    single_op("feq_qnan",   3'b010, QNAN,    ONE,   5'd4,  2'b10, 1'b0, 5'h00, 1'b0);
    single_op("feq_snan",   3'b010, SNAN,    ONE,   5'd5,  2'b10, 1'b0, 5'h10, 1'b0);
    single_op("fle_qnan",   3'b000, QNAN,    PZERO, 5'd6,  2'b00, 1'b0, 5'h10, 1'b0);
    single_op("illegal",    3'b011, ONE,     ONE,   5'd7,  2'b01, 1'b0, 5'h00, 1'b1);
    single_op("feq_1_1",    3'b010, ONE,     ONE,   5'd8,  2'b10, 1'b1, 5'h00, 1'b0);
    single_op("fle_2_1",    3'b000, TWO,     ONE,   5'd9,  2'b00, 1'b0, 5'h00, 1'b0);
    single_op("flt_neg",    3'b001, NEG_ONE, ONE,   5'd10, 2'b11, 1'b1, 5'h00, 1'b0);

    // Backpressure: two FIFO entries plus the output register fill up.
    bus.wb_ready = 1'b0;
    drive(3'b001, ONE, TWO, 5'd10);
    step();
    check("bp.ready1", 64'(bus.in_ready), 64'd1);
    drive(3'b010, ONE, TWO, 5'd11);
    step();
    check("bp.ready2", 64'(bus.in_ready), 64'd1);
    drive(3'b000, ONE, ONE, 5'd12);
    step();
    check("bp.ready3", 64'(bus.in_ready), 64'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      expect_wb("bp.hold", 1'b1, 5'h00, 5'd10, 1'b0);
      check("bp.full", 64'(bus.in_ready), 64'd0);
    end
    drive(3'b010, ONE, ONE, 5'd20);
    bus.wb_ready = 1'b1;
    step();
    idle();
    check("bp.free", 64'(bus.in_ready), 64'd1);
    expect_wb("bp.wb2", 1'b0, 5'h00, 5'd11, 1'b0);
    step();
    expect_wb("bp.wb3", 1'b1, 5'h00, 5'd12, 1'b0);
    step();
    check("bp.empty", 64'(bus.wb_valid), 64'd0);
    step();
    check("bp.nobypass", 64'(bus.wb_valid), 64'd0);

    // Back-to-back FEQ +0 vs -0 at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(3'b010, PZERO, NZERO, 5'(i + 1));
      step();
      check("b2b.ready", 64'(bus.in_ready), 64'd1);
      if (i > 0) expect_wb("b2b", 1'b1, 5'h00, 5'(i), 1'b0);
    end
    idle();
    step();
    expect_wb("b2b.last", 1'b1, 5'h00, 5'd8, 1'b0);
    step();
    check("b2b.drop", 64'(bus.wb_valid), 64'd0);

    // Flush with a full buffer and a pending writeback; concurrent push discarded.
    bus.wb_ready = 1'b0;
    drive(3'b001, ONE, TWO, 5'd1);
    step();
    drive(3'b001, ONE, TWO, 5'd2);
    step();
    drive(3'b001, ONE, TWO, 5'd3);
    step();
    check("fl.pre_valid", 64'(bus.wb_valid), 64'd1);
    check("fl.pre_ready", 64'(bus.in_ready), 64'd0);
    flush = 1'b1;
    drive(3'b001, ONE, TWO, 5'd9);
    step();
    flush = 1'b0;
    idle();
    check("fl.wb_valid", 64'(bus.wb_valid), 64'd0);
    check("fl.in_ready", 64'(bus.in_ready), 64'd1);
    check("fl.cmp_op",   64'(bus.cmp_op),   64'd1);
    bus.wb_ready = 1'b1;
    step();
    check("fl.after", 64'(bus.wb_valid), 64'd0);

    // Reset in the middle of traffic.
    bus.wb_ready = 1'b0;
    drive(3'b010, SNAN, ONE, 5'd7);
    step();
    drive(3'b001, ONE, TWO, 5'd8);
    step();
    idle();
    expect_wb("mid.pre", 1'b0, 5'h10, 5'd7, 1'b0);
    rst_n = 1'b0;
    step();
    check("mid.wb_valid",  64'(bus.wb_valid),  64'd0);
    check("mid.wb_data",   bus.wb_data,        64'd0);
    check("mid.wb_rd",     64'(bus.wb_rd),     64'd0);
    check("mid.wb_fflags", 64'(bus.wb_fflags), 64'd0);
    check("mid.in_ready",  64'(bus.in_ready),  64'd1);
    check("mid.cmp_op",    64'(bus.cmp_op),    64'd1);
    check("mid.cmp_a",     bus.cmp_a,          64'd0);
    rst_n = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    step();
    check("mid.after", 64'(bus.wb_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
